// File: rtl/i2c_arbiter_pkg.sv
// Shared types and defaults for the two-port EEPROM access arbiter.
package i2c_arbiter_pkg;

  localparam int unsigned WR_WAIT_CYC_DEF = 250_000;
  localparam int unsigned TIMEOUT_CYC_DEF = 1_000_000;
  localparam int unsigned ADDR_W          = 16;
  localparam int unsigned DATA_W          = 8;
  localparam int unsigned CNT_W           = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    BUSY    = 3'd2,
    WR_WAIT = 3'd3,
    DONE    = 3'd4
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_rec_t;

endpackage

// File: rtl/i2c_arbiter_edge_det.sv
// Two-flop synchroniser with rising-edge detect; reset level is a parameter so an
// idle-high line does not produce a false edge out of reset.
module i2c_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic din,
  output logic rise_c
);

  logic [1:0] sync;
  logic       prev;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync <= {2{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= {sync[0], din};
      prev <= sync[1];
    end
  end

  assign rise_c = sync[1] & ~prev;

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C EEPROM controller between two requesters,
// with write-cycle wait and transaction timeout.
module i2c_arbiter
  import i2c_arbiter_pkg::*;
#(
  parameter int unsigned WR_WAIT_CYC = WR_WAIT_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter logic        ADDR_NUM    = 1'b1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  input  logic              i2c_clk,
  input  logic              i2c_end,
  input  logic [DATA_W-1:0] ctl_rd_data,
  output logic              ctl_start,
  output logic              ctl_wr_en,
  output logic              ctl_rd_en,
  output logic              ctl_addr_num,
  output logic [ADDR_W-1:0] ctl_byte_addr,
  output logic [DATA_W-1:0] ctl_wr_data
);

  state_t            state, state_nxt;
  logic              clk_rise_c, end_rise_c;
  logic [CNT_W-1:0]  cnt;
  req_rec_t          gnt_q, sel_c;
  logic              gnt_port, last_port;
  logic              grant_c, pick_c, we_nxt_c, timeout_c;
  logic              start_nxt, wr_en_nxt, rd_en_nxt, done0_nxt, done1_nxt, err_nxt;

  i2c_edge_det #(.RST_VAL(1'b1)) u_clk_det (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .din(i2c_clk), .rise_c(clk_rise_c)
  );

  i2c_edge_det #(.RST_VAL(1'b0)) u_end_det (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .din(i2c_end), .rise_c(end_rise_c)
  );

  // On a tie the port not served last wins; otherwise the lone requester.
  assign grant_c   = (state == IDLE) && (req0 || req1);
  assign pick_c    = (req0 && req1) ? ~last_port : req1;
  assign sel_c     = pick_c ? req_rec_t'{we1, addr1, wdata1} : req_rec_t'{we0, addr0, wdata0};
  assign we_nxt_c  = grant_c ? sel_c.we : gnt_q.we;
  assign timeout_c = (state == BUSY) && !end_rise_c && (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 || req1) state_nxt = LAUNCH;
      LAUNCH:  if (clk_rise_c) state_nxt = BUSY;
      BUSY: begin
        if (end_rise_c)     state_nxt = gnt_q.we ? WR_WAIT : DONE;
        else if (timeout_c) state_nxt = DONE;
      end
      WR_WAIT: if (cnt == CNT_W'(WR_WAIT_CYC - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output values are decoded from the next state so the registers line up with it.
  always_comb begin
    start_nxt = 1'b0;
    wr_en_nxt = 1'b0;
    rd_en_nxt = 1'b0;
    done0_nxt = 1'b0;
    done1_nxt = 1'b0;
    err_nxt   = 1'b0;
    case (state_nxt)
      LAUNCH: begin
        start_nxt = 1'b1;
        wr_en_nxt = we_nxt_c;
        rd_en_nxt = ~we_nxt_c;
      end
      BUSY: begin
        wr_en_nxt = we_nxt_c;
        rd_en_nxt = ~we_nxt_c;
      end
      DONE: begin
        done0_nxt = ~gnt_port;
        done1_nxt = gnt_port;
        err_nxt   = timeout_c;
      end
      default: ;
    endcase
  end

  // Counter restarts on every state change and saturates instead of wrapping.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                cnt <= '0;
    else if (state_nxt != state)   cnt <= '0;
    else if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gnt_q     <= '0;
      gnt_port  <= 1'b0;
      last_port <= 1'b1;
    end else if (grant_c) begin
      gnt_q     <= sel_c;
      gnt_port  <= pick_c;
      last_port <= pick_c;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ctl_start    <= 1'b0;
      ctl_wr_en    <= 1'b0;
      ctl_rd_en    <= 1'b0;
      ctl_addr_num <= ADDR_NUM;
      done0        <= 1'b0;
      done1        <= 1'b0;
      err          <= 1'b0;
      rdata        <= '0;
    end else begin
      ctl_start    <= start_nxt;
      ctl_wr_en    <= wr_en_nxt;
      ctl_rd_en    <= rd_en_nxt;
      ctl_addr_num <= ADDR_NUM;
      done0        <= done0_nxt;
      done1        <= done1_nxt;
      err          <= err_nxt;
      if ((state == BUSY) && end_rise_c && !gnt_q.we) rdata <= ctl_rd_data;
    end
  end

  assign ctl_byte_addr = gnt_q.addr;
  assign ctl_wr_data   = gnt_q.wdata;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: drives a hand-stepped I2C controller model.
module tb_i2c_arbiter;

  localparam int unsigned WW = 20;
  localparam int unsigned TO = 1000;

  logic        sys_clk, sys_rst_n;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        done0, done1, err;
  logic [7:0]  rdata;
  logic        i2c_clk, i2c_end;
  logic [7:0]  ctl_rd_data;
  logic        ctl_start, ctl_wr_en, ctl_rd_en, ctl_addr_num;
  logic [15:0] ctl_byte_addr;
  logic [7:0]  ctl_wr_data;

  int checks = 0;
  int errors = 0;

  int          r_port, r_launch, r_to_done;
  bit          r_ok, r_start_held, r_wr_en, r_rd_en, r_err, r_single;
  logic [7:0]  r_rdata, r_wdata;
  logic [15:0] r_addr;

  i2c_arbiter #(.WR_WAIT_CYC(WW), .TIMEOUT_CYC(TO), .ADDR_NUM(1'b1)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata(rdata), .err(err),
    .i2c_clk(i2c_clk), .i2c_end(i2c_end), .ctl_rd_data(ctl_rd_data),
    .ctl_start(ctl_start), .ctl_wr_en(ctl_wr_en), .ctl_rd_en(ctl_rd_en),
    .ctl_addr_num(ctl_addr_num), .ctl_byte_addr(ctl_byte_addr), .ctl_wr_data(ctl_wr_data)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Controller model for one transaction; results land in the r_* variables.
  task automatic serve(input bit pulse_end, input bit drop_on_done, input bit drop_in_busy);
    int n;
    r_ok = 1'b0; r_port = -1; r_launch = 0; r_to_done = 0;
    n = 0;
    while (!ctl_start && n < 50) begin @(negedge sys_clk); n++; end
    if (!ctl_start) return;
    i2c_clk = 1'b0;
    repeat (3) @(negedge sys_clk);
    r_start_held = ctl_start;
    i2c_clk = 1'b1;
    n = 0;
    do begin @(posedge sys_clk); #1; n++; end while (ctl_start && n < 10);
    r_launch = n;
    if (ctl_start) begin @(negedge sys_clk); return; end
    r_wr_en = ctl_wr_en; r_rd_en = ctl_rd_en; r_addr = ctl_byte_addr; r_wdata = ctl_wr_data;
    if (drop_in_busy) begin req0 = 1'b0; req1 = 1'b0; end
    if (pulse_end) begin @(negedge sys_clk); i2c_end = 1'b1; end
    n = 0;
    do begin
      @(posedge sys_clk); #1; n++;
      if (n == 4) i2c_end = 1'b0;
    end while (!(done0 || done1) && n < int'(TO + WW + 50));
    i2c_end = 1'b0;
    if (!(done0 || done1)) begin @(negedge sys_clk); return; end
    r_ok = 1'b1; r_to_done = n; r_port = done1 ? 1 : 0; r_err = err; r_rdata = rdata;
    if (drop_on_done) begin if (done0) req0 = 1'b0; if (done1) req1 = 1'b0; end
    @(posedge sys_clk); #1;
    r_single = !(done0 || done1);
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    bit quiet;
    sys_rst_n = 1'b0; i2c_clk = 1'b1; i2c_end = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; ctl_rd_data = '0;
    repeat (3) @(negedge sys_clk);
    checks++; if ({done0, done1, err} !== 3'b000) begin errors++; $display("FAIL reset_done got %b required 000", {done0, done1, err}); end
    checks++; if ({ctl_start, ctl_wr_en, ctl_rd_en} !== 3'b000) begin errors++; $display("FAIL reset_ctl got %b required 000", {ctl_start, ctl_wr_en, ctl_rd_en}); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h required 00", rdata); end
    checks++; if (ctl_byte_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h required 0000", ctl_byte_addr); end
    checks++; if (ctl_wr_data !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h required 00", ctl_wr_data); end
    checks++; if (ctl_addr_num !== 1'b1) begin errors++; $display("FAIL reset_addr_num got %b required 1", ctl_addr_num); end
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    // i2c_end pulse with nothing in flight must be ignored
    quiet = 1'b1;
    i2c_end = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      if (i == 3) i2c_end = 1'b0;
      if (done0 || done1 || err || ctl_start) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL idle_end_ignored got %b required 1", quiet); end
  endtask

  task automatic test_write();
    we0 = 1'b1; addr0 = 16'h0055; wdata0 = 8'hA5; req0 = 1'b1;
    serve(1'b1, 1'b1, 1'b0);
    checks++; if (r_ok !== 1'b1) begin errors++; $display("FAIL wr_complete got %b required 1", r_ok); end
    checks++; if (r_start_held !== 1'b1) begin errors++; $display("FAIL wr_start_held got %b required 1", r_start_held); end
    checks++; if (r_launch !== 3) begin errors++; $display("FAIL wr_launch_edges got %0d required 3", r_launch); end
    checks++; if ({r_wr_en, r_rd_en} !== 2'b10) begin errors++; $display("FAIL wr_en got %b required 10", {r_wr_en, r_rd_en}); end
    checks++; if (r_addr !== 16'h0055) begin errors++; $display("FAIL wr_addr got %h required 0055", r_addr); end
    checks++; if (r_wdata !== 8'hA5) begin errors++; $display("FAIL wr_wdata got %h required a5", r_wdata); end
    // end sampled at P0, detected after P1, WR_WAIT from P2, DONE at P(2+WW)
    checks++; if (r_to_done !== int'(WW + 3)) begin errors++; $display("FAIL wr_wait_len got %0d required %0d", r_to_done, WW + 3); end
    checks++; if (r_port !== 0) begin errors++; $display("FAIL wr_port got %0d required 0", r_port); end
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL wr_err got %b required 0", r_err); end
    checks++; if (r_single !== 1'b1) begin errors++; $display("FAIL wr_done_width got %b required 1", r_single); end
    checks++; if (ctl_wr_en !== 1'b0) begin errors++; $display("FAIL wr_en_idle got %b required 0", ctl_wr_en); end
  endtask

  task automatic test_read();
    we1 = 1'b0; addr1 = 16'h0055; ctl_rd_data = 8'hA5; req1 = 1'b1;
    serve(1'b1, 1'b1, 1'b0);
    checks++; if (r_port !== 1) begin errors++; $display("FAIL rd_port got %0d required 1", r_port); end
    checks++; if ({r_wr_en, r_rd_en} !== 2'b01) begin errors++; $display("FAIL rd_en got %b required 01", {r_wr_en, r_rd_en}); end
    checks++; if (r_to_done !== 3) begin errors++; $display("FAIL rd_no_wait got %0d required 3", r_to_done); end
    checks++; if (r_rdata !== 8'hA5) begin errors++; $display("FAIL rd_data got %h required a5", r_rdata); end
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL rd_err got %b required 0", r_err); end
  endtask

  task automatic test_back_to_back();
    int exp_order [6] = '{0, 1, 0, 1, 0, 1};
    we0 = 1'b0; we1 = 1'b0; ctl_rd_data = 8'h5A;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      serve(1'b1, k >= 4, 1'b0);
      checks++; if (r_port !== exp_order[k]) begin errors++; $display("FAIL rr_order[%0d] got %0d required %0d", k, r_port, exp_order[k]); end
    end
    checks++; if (rdata !== 8'h5A) begin errors++; $display("FAIL rr_rdata got %h required 5a", rdata); end
  endtask

  task automatic test_timeout();
    we0 = 1'b0; ctl_rd_data = 8'h3C; req0 = 1'b1;
    serve(1'b0, 1'b1, 1'b0);
    checks++; if (r_to_done !== int'(TO)) begin errors++; $display("FAIL to_len got %0d required %0d", r_to_done, TO); end
    checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL to_err got %b required 1", r_err); end
    checks++; if (r_rdata !== 8'h5A) begin errors++; $display("FAIL to_rdata got %h required 5a", r_rdata); end
    checks++; if (r_single !== 1'b1) begin errors++; $display("FAIL to_done_width got %b required 1", r_single); end
  endtask

  task automatic test_drop();
    bit regrant;
    we0 = 1'b0; ctl_rd_data = 8'h11; req0 = 1'b1;
    serve(1'b1, 1'b0, 1'b1);
    checks++; if (r_port !== 0) begin errors++; $display("FAIL drop_done_port got %0d required 0", r_port); end
    checks++; if (r_rdata !== 8'h11) begin errors++; $display("FAIL drop_rdata got %h required 11", r_rdata); end
    regrant = 1'b0;
    repeat (20) begin @(negedge sys_clk); if (ctl_start || done0) regrant = 1'b1; end
    checks++; if (regrant !== 1'b0) begin errors++; $display("FAIL drop_regrant got %b required 0", regrant); end
  endtask

  task automatic test_reset_busy();
    int n;
    we1 = 1'b0; addr1 = 16'h1234; req1 = 1'b1;
    n = 0;
    while (!ctl_start && n < 50) begin @(negedge sys_clk); n++; end
    i2c_clk = 1'b0;
    repeat (3) @(negedge sys_clk);
    i2c_clk = 1'b1;
    n = 0;
    while (ctl_start && n < 10) begin @(negedge sys_clk); n++; end
    checks++; if ({ctl_start, ctl_rd_en, ctl_byte_addr} !== {2'b01, 16'h1234}) begin errors++; $display("FAIL rb_in_busy got %b_%b_%h required 0_1_1234", ctl_start, ctl_rd_en, ctl_byte_addr); end
    sys_rst_n = 1'b0;
    #1;
    checks++; if ({done0, done1, err, ctl_start, ctl_wr_en, ctl_rd_en} !== 6'b0) begin errors++; $display("FAIL rb_flags got %b required 000000", {done0, done1, err, ctl_start, ctl_wr_en, ctl_rd_en}); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rb_rdata got %h required 00", rdata); end
    checks++; if (ctl_byte_addr !== 16'h0000) begin errors++; $display("FAIL rb_addr got %h required 0000", ctl_byte_addr); end
    checks++; if (ctl_addr_num !== 1'b1) begin errors++; $display("FAIL rb_addr_num got %b required 1", ctl_addr_num); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    // both pending after reset: port 0 must be favoured
    we0 = 1'b0; ctl_rd_data = 8'h77; req0 = 1'b1;
    serve(1'b1, 1'b1, 1'b0);
    checks++; if (r_port !== 0) begin errors++; $display("FAIL rb_first_port got %0d required 0", r_port); end
    checks++; if (r_rdata !== 8'h77) begin errors++; $display("FAIL rb_rdata_after got %h required 77", r_rdata); end
    serve(1'b1, 1'b1, 1'b0);
    checks++; if (r_port !== 1) begin errors++; $display("FAIL rb_second_port got %0d required 1", r_port); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_timeout();
    test_drop();
    test_reset_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
